// File: rtl/cc_pkg.sv
// Shared types and default geometry for the cache line-fill engine.
package cc_pkg;

   localparam int unsigned CC_ADDR_W     = 32;
   localparam int unsigned CC_DATA_W     = 64;
   localparam int unsigned CC_LINE_BYTES = 64;
   localparam int unsigned CC_IDX_W      = 9;
   localparam int unsigned CC_OFS_W      = $clog2(CC_LINE_BYTES);
   localparam int unsigned CC_TAG_W      = CC_ADDR_W - CC_IDX_W - CC_OFS_W;

   localparam logic [1:0] RRESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } fill_state_e;

   typedef struct packed {
      logic [CC_TAG_W-1:0] tag;
      logic [CC_IDX_W-1:0] idx;
      logic [CC_OFS_W-1:0] ofs;
   } cc_addr_t;

endpackage

// File: rtl/cc_beat_assembler.sv
// Line buffer for cc_line_fill_engine: places R beats into their wrap-order slot and
// keeps the sticky per-line error flag.
module cc_beat_assembler
   import cc_pkg::*;
#(
   parameter  int unsigned DATA_W     = CC_DATA_W,
   parameter  int unsigned LINE_BYTES = CC_LINE_BYTES,
   localparam int unsigned LINE_W     = LINE_BYTES * 8,
   localparam int unsigned BEATS      = LINE_W / DATA_W,
   localparam int unsigned SW_W       = $clog2(BEATS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              beat_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rlast_i,
   input  logic [SW_W-1:0]   start_word_i,
   output logic [LINE_W-1:0] line_o,
   output logic              first_o,
   output logic              done_o,
   output logic              err_o,
   output logic              err_next_o
);

   logic [LINE_W-1:0] line_q, line_d;
   logic [SW_W-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              last_cnt;
   logic              beat_err;
   logic [SW_W-1:0]   slot;

   assign last_cnt = (cnt_q == SW_W'(BEATS - 1));
   // BEATS is a power of two, so the SW_W-bit sum wraps exactly at the line end
   assign slot     = start_word_i + cnt_q;
   assign beat_err = (rresp_i != RRESP_OKAY) | (rlast_i & ~last_cnt) | (last_cnt & ~rlast_i);

   always_comb begin
      line_d = line_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (clear_i) begin
         cnt_d = '0;
         err_d = 1'b0;
      end else if (beat_i) begin
         for (int unsigned w = 0; w < BEATS; w++) begin
            if (slot == SW_W'(w)) line_d[LINE_W-1-w*DATA_W -: DATA_W] = rdata_i;
         end
         cnt_d = cnt_q + 1'b1;
         err_d = err_q | beat_err;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign line_o     = line_q;
   assign first_o    = (cnt_q == '0);
   assign done_o     = beat_i & (rlast_i | last_cnt);
   assign err_o      = err_q;
   assign err_next_o = err_d;

endmodule

// File: rtl/cc_line_fill_engine.sv
// Cache line-fill engine: FSM and FIFO/SRAM handshakes around cc_beat_assembler.
// Define CC_CWF_EN to enable the critical-word-first strobe.
module cc_line_fill_engine
   import cc_pkg::*;
#(
   parameter  int unsigned ADDR_W     = CC_ADDR_W,
   parameter  int unsigned DATA_W     = CC_DATA_W,
   parameter  int unsigned LINE_BYTES = CC_LINE_BYTES,
   parameter  int unsigned IDX_W      = CC_IDX_W,
   localparam int unsigned LINE_W     = LINE_BYTES * 8,
   localparam int unsigned BEATS      = LINE_W / DATA_W,
   localparam int unsigned SW_W       = $clog2(BEATS),
   localparam int unsigned OFS_W      = $clog2(LINE_BYTES),
   localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [1:0]        mem_rresp_i,
   input  logic              mem_rlast_i,
   input  logic              mem_rvalid_i,
   output logic              mem_rready_o,
   input  logic              miss_addr_fifo_empty_i,
   input  logic [ADDR_W-1:0] miss_addr_fifo_rdata_i,
   output logic              miss_addr_fifo_rden_o,
   output logic              wren_o,
   output logic [IDX_W-1:0]  waddr_o,
   output logic [TAG_W:0]    wdata_tag_o,
   output logic [LINE_W-1:0] wdata_data_o,
   output logic              fill_busy_o,
   output logic              fill_err_o,
   output logic              cwf_valid_o,
   output logic [DATA_W-1:0] cwf_data_o
);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              vld_q, vld_d;
   logic              in_fill;
   logic              in_write;
   logic              hs;
   logic              load;
   logic              done;
   logic              err_q;
   logic              err_next;
   logic              beat0;

   assign in_fill  = (state_q == FILL);
   assign in_write = (state_q == WRITE);
   assign hs       = in_fill & mem_rvalid_i;
   assign load     = ~miss_addr_fifo_empty_i & ((state_q == IDLE) | in_write);

   cc_beat_assembler #(
      .DATA_W     (DATA_W),
      .LINE_BYTES (LINE_BYTES)
   ) u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (load),
      .beat_i       (hs),
      .rdata_i      (mem_rdata_i),
      .rresp_i      (mem_rresp_i),
      .rlast_i      (mem_rlast_i),
      .start_word_i (addr_q[OFS_W-1 -: SW_W]),
      .line_o       (wdata_data_o),
      .first_o      (beat0),
      .done_o       (done),
      .err_o        (err_q),
      .err_next_o   (err_next)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      vld_d   = vld_q;
      if (load) addr_d = miss_addr_fifo_rdata_i;
      // valid bit is registered so the tag word stays stable between writes
      if (done) vld_d = ~err_next;
      case (state_q)
         IDLE:    if (load) state_d = FILL;
         FILL:    if (done) state_d = WRITE;
         WRITE:   state_d = load ? FILL : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         vld_q   <= vld_d;
      end
   end

   if (OFS_W > SW_W) begin : g_lsb
      logic lsb_unused;
      assign lsb_unused = ^addr_q[OFS_W-SW_W-1:0];
   end

   assign mem_rready_o          = rst_n & in_fill;
   assign miss_addr_fifo_rden_o = rst_n & load;
   assign wren_o                = rst_n & in_write;
   assign fill_err_o            = rst_n & in_write & err_q;
   assign fill_busy_o           = rst_n & (state_q != IDLE);
   assign waddr_o               = addr_q[OFS_W +: IDX_W];
   assign wdata_tag_o           = {vld_q, addr_q[ADDR_W-1 -: TAG_W]};

`ifdef CC_CWF_EN
   assign cwf_valid_o = rst_n & hs & beat0;
   assign cwf_data_o  = rst_n ? mem_rdata_i : '0;
`else
   logic beat0_unused;
   assign beat0_unused = beat0;
   assign cwf_valid_o  = 1'b0;
   assign cwf_data_o   = '0;
`endif

endmodule

// File: tb/tb_cc_line_fill_engine.sv
// Bench for cc_line_fill_engine: directed scenarios then random fills, each cycle
// checked against a line-level reference model (stale words, wrap order, errors).
`timescale 1ns/1ps
module tb_cc_line_fill_engine;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 64;
   localparam int unsigned LINE_BYTES = 64;
   localparam int unsigned IDX_W      = 9;
   localparam int unsigned LINE_W     = LINE_BYTES * 8;
   localparam int unsigned BEATS      = LINE_W / DATA_W;
   localparam int unsigned OFS_W      = $clog2(LINE_BYTES);
   localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFS_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] mem_rdata;
   logic [1:0]        mem_rresp;
   logic              mem_rlast;
   logic              mem_rvalid;
   logic              mem_rready;
   logic              fifo_empty;
   logic [ADDR_W-1:0] fifo_rdata;
   logic              fifo_rden;
   logic              wren;
   logic [IDX_W-1:0]  waddr;
   logic [TAG_W:0]    wtag;
   logic [LINE_W-1:0] wdata;
   logic              busy;
   logic              ferr;
   logic              cwf_valid;
   logic [DATA_W-1:0] cwf_data;

   always #5 clk = ~clk;

   cc_line_fill_engine dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .mem_rdata_i            (mem_rdata),
      .mem_rresp_i            (mem_rresp),
      .mem_rlast_i            (mem_rlast),
      .mem_rvalid_i           (mem_rvalid),
      .mem_rready_o           (mem_rready),
      .miss_addr_fifo_empty_i (fifo_empty),
      .miss_addr_fifo_rdata_i (fifo_rdata),
      .miss_addr_fifo_rden_o  (fifo_rden),
      .wren_o                 (wren),
      .waddr_o                (waddr),
      .wdata_tag_o            (wtag),
      .wdata_data_o           (wdata),
      .fill_busy_o            (busy),
      .fill_err_o             (ferr),
      .cwf_valid_o            (cwf_valid),
      .cwf_data_o             (cwf_data)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      int                last_at;   // beat index carrying rlast (BEATS = never)
      int                bad_at;    // beat index with a non-OKAY response (-1 = none)
   } plan_t;

   plan_t             fifo_q[$];
   plan_t             act;
   bit                act_busy;
   int                k;
   bit                m_err;
   logic [DATA_W-1:0] mline [BEATS];
   logic [DATA_W-1:0] blog  [BEATS];
   bit                wr_pending;
   logic [IDX_W-1:0]  e_idx;
   logic [TAG_W:0]    e_tag;
   logic [LINE_W-1:0] e_line;
   bit                e_err;
   bit                rst_prev_low;
   int                rv_pct, garbage_pct;
   int                cyc_n, rden_cnt, wren_cnt, ferr_cnt, hs_cnt;
   int                wr_cyc[$];
   int                checks, failures;
   logic [LINE_W-1:0] wd;
   int                n0, n1;

   task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                        input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_line(input logic [ADDR_W-1:0] a, input int last_at, input int bad_at);
      plan_t p;
      p.addr = a; p.last_at = last_at; p.bad_at = bad_at;
      fifo_q.push_back(p);
   endtask

   // One clock: drive at negedge, check #1 later, advance the model, wait next negedge.
   task automatic cyc();
      logic hs;
      bit   do_pop;
      int   slot;
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = fifo_empty ? ADDR_W'($urandom) : fifo_q[0].addr;
      mem_rdata  = {$urandom, $urandom};
      if (act_busy) begin
         mem_rvalid = ($urandom_range(0, 99) < rv_pct);
         mem_rlast  = (k == act.last_at);
         mem_rresp  = (k == act.bad_at) ? 2'($urandom_range(1, 3)) : 2'b00;
      end else begin
         mem_rvalid = ($urandom_range(0, 99) < garbage_pct);
         mem_rlast  = 1'($urandom_range(0, 1));
         mem_rresp  = 2'($urandom_range(0, 3));
      end
      #1;
      hs = mem_rvalid & act_busy;
      if (!rst_n) begin
         check("rst_rready", mem_rready, 0);
         check("rst_rden", fifo_rden, 0);
         check("rst_wren", wren, 0);
         check("rst_ferr", ferr, 0);
         check("rst_busy", busy, 0);
         check("rst_cwf_valid", cwf_valid, 0);
         check("rst_cwf_data", cwf_data, 0);
         if (rst_prev_low) begin
            check("rst_waddr", waddr, 0);
            check("rst_tag", wtag, 0);
            check("rst_data", wdata, 0);
         end
      end else begin
         check("rready", mem_rready, act_busy);
         check("rden", fifo_rden, !fifo_empty && !act_busy);
         check("busy", busy, act_busy || wr_pending);
         check("wren", wren, wr_pending);
         check("fill_err", ferr, wr_pending && e_err);
         if (wr_pending) begin
            check("waddr", waddr, e_idx);
            check("wtag", wtag, e_tag);
            check("wdata", wdata, e_line);
         end
`ifdef CC_CWF_EN
         check("cwf_valid", cwf_valid, hs && k == 0);
         if (hs && k == 0) check("cwf_data", cwf_data, mem_rdata);
`else
         check("cwf_valid_off", cwf_valid, 0);
         check("cwf_data_off", cwf_data, 0);
`endif
         if (fifo_rden) rden_cnt++;
         if (wren) begin wren_cnt++; wr_cyc.push_back(cyc_n); end
         if (ferr) ferr_cnt++;
      end

      if (!rst_n) begin
         foreach (mline[i]) mline[i] = '0;
         fifo_q.delete();
         act_busy = 0; wr_pending = 0; k = 0; m_err = 0;
      end else begin
         do_pop     = !fifo_empty && !act_busy;
         wr_pending = 0;
         if (hs) begin
            hs_cnt++;
            slot = (int'((act.addr % LINE_BYTES) / (DATA_W / 8)) + k) % BEATS;
            mline[slot] = mem_rdata;
            blog[k]     = mem_rdata;
            if (mem_rresp != 2'b00 || (mem_rlast && k != BEATS - 1) ||
                (k == BEATS - 1 && !mem_rlast)) m_err = 1;
            if (mem_rlast || k == BEATS - 1) begin
               act_busy   = 0;
               wr_pending = 1;
               e_err      = m_err;
               e_idx      = IDX_W'((act.addr / LINE_BYTES) % (1 << IDX_W));
               e_tag      = {~m_err, TAG_W'(act.addr / (LINE_BYTES * (1 << IDX_W)))};
               for (int w = 0; w < BEATS; w++) e_line[LINE_W-1-w*DATA_W -: DATA_W] = mline[w];
            end
            k++;
         end
         if (do_pop) begin
            act = fifo_q.pop_front();
            act_busy = 1; k = 0; m_err = 0;
            foreach (blog[i]) blog[i] = '0;
         end
      end
      rst_prev_low = !rst_n;
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || act_busy || wr_pending) && n < max_cyc) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      checks = 0; failures = 0; cyc_n = 0;
      rden_cnt = 0; wren_cnt = 0; ferr_cnt = 0; hs_cnt = 0;
      act_busy = 0; wr_pending = 0; k = 0; m_err = 0; rst_prev_low = 0;
      foreach (mline[i]) mline[i] = '0;
      foreach (blog[i]) blog[i] = '0;
      rst_n = 1'b0; mem_rvalid = 0; mem_rlast = 0; mem_rresp = 0; mem_rdata = '0;
      fifo_empty = 1; fifo_rdata = '0;
      rv_pct = 100; garbage_pct = 0;
      @(negedge clk);
      repeat (3) cyc();
      rst_n = 1'b1;

      // 1: aligned full line
      n0 = rden_cnt;
      push_line(32'h1234_5640, BEATS - 1, -1);
      drain(100);
      check("t1_rden_pulses", rden_cnt - n0, 1);
      check("t1_waddr", waddr, 9'h159);
      check("t1_tag", wtag, {1'b1, 17'h02468});
      wd = wdata;
      check("t1_word0_msb", wd[LINE_W-1 -: DATA_W], blog[0]);
      check("t1_word7_lsb", wd[DATA_W-1:0], blog[7]);

      // 2: critical word first, start_word 5, with bubbles and stray rvalid while idle
      rv_pct = 60; garbage_pct = 50;
      push_line(32'h0ABC_D028, BEATS - 1, -1);
      drain(200);
      wd = wdata;
      check("t2_slot5_A", wd[LINE_W-1-5*DATA_W -: DATA_W], blog[0]);
      check("t2_slot0_D", wd[LINE_W-1 -: DATA_W], blog[3]);
      check("t2_slot4_H", wd[LINE_W-1-4*DATA_W -: DATA_W], blog[7]);

      // 3: early rlast on beat 4
      n0 = ferr_cnt; n1 = hs_cnt;
      push_line(32'h0000_7FC0, 4, -1);
      drain(200);
      check("t3_ferr_pulses", ferr_cnt - n0, 1);
      check("t3_beats", hs_cnt - n1, 5);
      check("t3_valid_bit", wtag[TAG_W], 0);
      check("t3_idle", busy, 0);

      // 4: SLVERR-style response on beat 3, full burst still consumed
      n0 = ferr_cnt; n1 = hs_cnt;
      push_line(32'hFFFF_FFC8, BEATS - 1, 3);
      drain(200);
      check("t4_ferr_pulses", ferr_cnt - n0, 1);
      check("t4_beats", hs_cnt - n1, 8);
      check("t4_valid_bit", wtag[TAG_W], 0);

      // 5: back-to-back fills, rvalid held high
      rv_pct = 100; garbage_pct = 100;
      n0 = wren_cnt; n1 = rden_cnt;
      push_line(32'h8000_0100, BEATS - 1, -1);
      push_line(32'h8000_0218, BEATS - 1, -1);
      drain(100);
      check("t5_wren_pulses", wren_cnt - n0, 2);
      check("t5_rden_pulses", rden_cnt - n1, 2);
      check("t5_wren_gap", wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2], 9);

      // 6: reset after beat 5, then a clean fill
      garbage_pct = 0;
      n0 = wren_cnt;
      push_line(32'h4321_0040, BEATS - 1, -1);
      for (int n = 0; n < 30 && !(act_busy && k == 6); n++) cyc();
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      check("t6_no_wren", wren_cnt - n0, 0);
      push_line(32'h4321_0078, BEATS - 1, -1);
      drain(100);
      check("t6_refill_wrens", wren_cnt - n0, 1);

      // random mix
      for (int it = 0; it < 30; it++) begin
         int r;
         rv_pct      = $urandom_range(40, 100);
         garbage_pct = $urandom_range(0, 100);
         for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
            r = $urandom_range(0, 99);
            push_line(ADDR_W'($urandom),
                      (r < 70) ? BEATS - 1 : (r < 85) ? int'($urandom_range(0, BEATS - 2)) : BEATS,
                      ($urandom_range(0, 99) < 20) ? int'($urandom_range(0, BEATS - 1)) : -1);
         end
         drain(400);
         repeat ($urandom_range(0, 2)) cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
